// File: rtl/ft245_sync_stream_tx.sv
// FT245 synchronous-mode transmit streamer: buffers source words in a FIFO and sends them
// least-significant byte first over the FT2232H bus, or sends an incrementing test pattern.
module ft245_sync_stream_tx #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 32,
    parameter int BLINK_BIT  = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic                  mode_i,
    input  logic                  enable_i,
    inout  wire  [7:0]            adbus_io,
    input  logic                  txe_i,
    output logic                  wr_n_o,
    output logic                  oe_n_o,
    output logic [DEPTH_LOG2:0]   fifo_level_o,
    output logic [CNT_W-1:0]      tx_bytes_o,
    output logic                  blinker_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(BYTES - 1);
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ZERO = (DEPTH_LOG2 + 1)'(0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic [DEPTH_LOG2:0]   level_nxt_s;
    logic                  ready_r;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [DATA_W-1:0]     shift_r;
    logic [DATA_W-1:0]     shift_nxt_s;
    logic [DATA_W-1:0]     fifo_word_s;
    logic [IDX_W-1:0]      byte_idx_r;
    logic                  word_mode_r;
    logic [7:0]            pat_r;
    logic [7:0]            pat_nxt_s;
    logic [7:0]            data_r;
    logic                  wr_n_r;
    logic [CNT_W-1:0]      tx_bytes_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  load_pat_s;
    logic                  empty_s;
    logic                  consume_s;
    logic                  last_s;
    logic                  at_boundary_s;
    logic                  start_word_s;
    logic                  start_pat_s;
    logic                  wr_n_nxt_s;

    assign push_s        = s_valid_i && ready_r;
    assign empty_s       = (level_r == LEVEL_ZERO);
    assign fifo_word_s   = mem_r[rd_ptr_r];
    assign shift_nxt_s   = shift_r >> 4'd8;
    // A byte leaves only when the FT sees WR# low with TXE# low on the same edge.
    assign consume_s     = (state_r == S_SEND) && !wr_n_r && !txe_i;
    // Pattern mode treats every byte as its own word, so mode/enable are re-sampled per byte.
    assign last_s        = word_mode_r || (byte_idx_r == LAST_IDX);
    assign at_boundary_s = (state_r == S_IDLE) || (consume_s && last_s);
    assign start_pat_s   = enable_i && mode_i;
    assign start_word_s  = enable_i && !mode_i && !empty_s;
    assign pat_nxt_s     = (consume_s && word_mode_r) ? (pat_r + 8'd1) : pat_r;

    assign s_ready_o    = ready_r;
    assign fifo_level_o = level_r;
    assign tx_bytes_o   = tx_bytes_r;
    assign blinker_o    = tx_bytes_r[BLINK_BIT];
    assign wr_n_o       = wr_n_r;
    assign oe_n_o       = 1'b1;
    assign adbus_io     = data_r;

    // FIFO level after this cycle's push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_nxt_s = level_r - (DEPTH_LOG2 + 1)'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data_i;
        end
    end

    // FIFO pointers, level and registered ready.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= DEPTH_LOG2'(0);
            rd_ptr_r <= DEPTH_LOG2'(0);
            level_r  <= LEVEL_ZERO;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != LEVEL_FULL);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave S_SEND only after the last byte of a word with nothing to follow.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_pat_s || start_word_s) begin
                    state_nxt_s = S_SEND;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (consume_s && last_s) begin
                    if (start_pat_s || start_word_s) begin
                        state_nxt_s = S_SEND;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_SEND;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output/control decode: word pop, pattern load and the next WR# level.
    always_comb begin
        pop_s      = at_boundary_s && start_word_s;
        load_pat_s = at_boundary_s && start_pat_s;
        wr_n_nxt_s = !((state_nxt_s == S_SEND) && !txe_i && enable_i);
    end

    // Datapath: bus byte, shift register, pattern generator, byte counter and WR#.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shift_r     <= DATA_W'(0);
            byte_idx_r  <= IDX_W'(0);
            word_mode_r <= 1'b0;
            pat_r       <= 8'h00;
            data_r      <= 8'h00;
            wr_n_r      <= 1'b1;
            tx_bytes_r  <= CNT_W'(0);
        end else begin
            pat_r  <= pat_nxt_s;
            wr_n_r <= wr_n_nxt_s;
            if (consume_s) begin
                tx_bytes_r <= tx_bytes_r + CNT_W'(1);
            end
            if (pop_s) begin
                shift_r     <= fifo_word_s;
                data_r      <= fifo_word_s[7:0];
                byte_idx_r  <= IDX_W'(0);
                word_mode_r <= 1'b0;
            end else if (load_pat_s) begin
                data_r      <= pat_nxt_s;
                word_mode_r <= 1'b1;
            end else if (consume_s && !last_s) begin
                shift_r    <= shift_nxt_s;
                data_r     <= shift_nxt_s[7:0];
                byte_idx_r <= byte_idx_r + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ft245_sync_stream_tx.sv
// Directed self-checking bench for ft245_sync_stream_tx (DATA_W=16, 16-word FIFO, blinker on bit 8).
module tb_ft245_sync_stream_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mode;
    logic        enable;
    wire  [7:0]  adbus;
    logic        txe;
    logic        wr_n;
    logic        oe_n;
    logic [4:0]  level;
    logic [31:0] tx_bytes;
    logic        blinker;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bad;
    logic [7:0] q [$];
    int         qc [$];

    ft245_sync_stream_tx #(
        .DATA_W(16), .DEPTH_LOG2(4), .CNT_W(32), .BLINK_BIT(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready), .mode_i(mode), .enable_i(enable), .adbus_io(adbus),
        .txe_i(txe), .wr_n_o(wr_n), .oe_n_o(oe_n), .fifo_level_o(level),
        .tx_bytes_o(tx_bytes), .blinker_o(blinker)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    // Capture every byte the FT would accept, with the cycle it was taken on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && !wr_n && !txe) begin
            q.push_back(adbus);
            qc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; txe = 1'b0; mode = 1'b0; enable = 1'b1;
        s_valid = 1'b0; s_data = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_wr_n", wr_n, 1'b1);
        check("rst_oe_n", oe_n, 1'b1);
        check("rst_adbus", adbus, 8'h00);
        check("rst_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", s_ready, 1'b1);
        check("idle_level", level, 5'd0);

        // Two words back to back: 11,22,33,44 on consecutive edges.
        s_valid = 1'b1; s_data = 16'h2211;
        @(negedge clk);
        s_data = 16'h4433;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_count", q.size(), 4);
        check("b2b_b0", q[0], 8'h11);
        check("b2b_b1", q[1], 8'h22);
        check("b2b_b2", q[2], 8'h33);
        check("b2b_b3", q[3], 8'h44);
        check("b2b_nogap", qc[3] - qc[0], 3);
        check("b2b_wr_n", wr_n, 1'b1);
        check("b2b_tx", tx_bytes, 32'd4);

        // TXE# stall after the first byte of 0x2211.
        q.delete(); qc.delete();
        s_valid = 1'b1; s_data = 16'h2211;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 20 && q.size() < 1; k++) @(negedge clk);
        check("stall_first", q.size(), 1);
        txe = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_hold_bus", adbus, 8'h22);
        check("stall_wr_n", wr_n, 1'b1);
        check("stall_none", q.size(), 1);
        txe = 1'b0;
        repeat (6) @(negedge clk);
        check("stall_count", q.size(), 2);
        check("stall_b1", q[1], 8'h22);
        check("stall_tx", tx_bytes, 32'd6);

        // Fill the FIFO with launch disabled and TXE# high, then drain all 32 bytes.
        q.delete(); qc.delete();
        enable = 1'b0; txe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fill_ready", s_ready, 1'b1);
            s_valid = 1'b1;
            s_data = {8'(2 * i + 1), 8'(2 * i)};
            @(negedge clk);
        end
        check("full_level", level, 5'd16);
        check("full_ready", s_ready, 1'b0);
        s_data = 16'hDEAD;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        check("full_no_push", level, 5'd16);
        enable = 1'b1; txe = 1'b0;
        repeat (60) @(negedge clk);
        check("drain_count", q.size(), 32);
        bad = 0;
        for (int i = 0; i < 32; i++) if (q[i] !== 8'(i)) bad++;
        check("drain_order", bad, 0);
        check("drain_level", level, 5'd0);
        check("drain_tx", tx_bytes, 32'd38);

        // Pattern mode from a fresh reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("pat_tx0", tx_bytes, 32'd0);
        q.delete(); qc.delete();
        mode = 1'b1;
        repeat (256) @(negedge clk);
        check("pat_tx255", tx_bytes, 32'd255);
        check("pat_blink0", blinker, 1'b0);
        repeat (44) @(negedge clk);
        mode = 1'b0;
        repeat (5) @(negedge clk);
        check("pat_count", q.size(), 300);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (q[i] !== 8'(i)) bad++;
            if (qc[i] !== qc[0] + i) bad++;
        end
        check("pat_seq", bad, 0);
        check("pat_tx", tx_bytes, 32'd300);
        check("pat_blink1", blinker, 1'b1);
        check("pat_idle_wr_n", wr_n, 1'b1);

        // Reset after the first byte of 0x6655: partial word is dropped.
        q.delete(); qc.delete();
        s_valid = 1'b1; s_data = 16'h6655;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 20 && q.size() < 1; k++) @(negedge clk);
        check("mid_first", q.size(), 1);
        check("mid_b0", q[0], 8'h55);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_n", wr_n, 1'b1);
        check("mid_rst_adbus", adbus, 8'h00);
        check("mid_rst_ready", s_ready, 1'b0);
        check("mid_rst_tx", tx_bytes, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_level", level, 5'd0);
        check("mid_ready", s_ready, 1'b1);
        repeat (5) @(negedge clk);
        check("mid_no_more", q.size(), 1);
        check("mid_tx", tx_bytes, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
